bus_if_merge: RTL and testbench
===============================

BUS_IF_MERGE -- requirements
Module: bus_if_merge

Interface
REQ-001 The module SHALL have parameter NUM_IN_FLIGHT, default 4, giving the maximum number of accepted commands with responses still pending; the legal range is 2 or more.
REQ-002 The module SHALL have port Clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port MReset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have port in_0, Bus_if.slave: master port 0 (higher priority on the first tie).
REQ-005 The module SHALL have port in_1, Bus_if.slave: master port 1.
REQ-006 The module SHALL have port out, Bus_if.master: the merged port toward the single slave.
REQ-007 out.MReset_n SHALL be driven directly from MReset_n.

Function
REQ-008 Arbiter states SHALL be ARB_FREE, ARB_HOLD_0 and ARB_HOLD_1; a last_grant register SHALL record the most recently accepted port.
REQ-009 Grant in ARB_FREE SHALL be:
- only one port has MCmd != IDLE: that port;
- both do: the port != last_grant (round-robin);
- neither: no grant.
REQ-010 In ARB_HOLD_x the grant SHALL be port x, regardless of the other port.
REQ-011 In ARB_FREE, a granted command not accepted (out.SCmdAccept=0, or blocked by full) SHALL move the state to ARB_HOLD_x.
REQ-012 In ARB_HOLD_x, an accepted command SHALL return the state to ARB_FREE; otherwise the state SHALL remain ARB_HOLD_x.
REQ-013 On every accept, last_grant SHALL be set to the granted index.
REQ-014 out.MAddr, out.MData and out.MByteEn SHALL equal the granted port's fields combinationally (in_0's fields when there is no grant).
REQ-015 out.MCmd SHALL be the granted MCmd when a grant exists and the FIFO is not full, and Bus::IDLE otherwise.
REQ-016 The granted port's SCmdAccept SHALL equal out.SCmdAccept gated by !full; the non-granted port's SCmdAccept SHALL be 0.
REQ-017 The command path SHALL add zero cycles of latency.
REQ-018 Push SHALL occur when out.MCmd != IDLE and out.SCmdAccept=1; push data SHALL be the granted index (1 bit).
REQ-019 Every accepted command, reads and writes alike, SHALL produce exactly one response.
REQ-020 When the FIFO is empty:
- both in_x.SResp SHALL be Bus::NULL and in_x.SData SHALL be '0;
- out.MRespAccept SHALL be 0.
REQ-021 When the FIFO is not empty and the head is h:
- in_h.SResp and in_h.SData SHALL equal out.SResp and out.SData;
- the other port SHALL see Bus::NULL and '0;
- out.MRespAccept SHALL equal in_h.MRespAccept.
REQ-022 Pop SHALL occur when the FIFO is not empty, out.SResp != Bus::NULL and in_h.MRespAccept=1.
REQ-023 The response path SHALL add zero cycles of latency, and responses SHALL return in command-acceptance order.
REQ-024 full and empty SHALL be registered state only: when full, a pop in the same cycle SHALL NOT unblock a push; when empty, a push in the same cycle SHALL NOT enable a response.
REQ-025 A simultaneous push and pop when not empty and not full SHALL leave the occupancy unchanged.
REQ-026 FIFO pointers SHALL wrap modulo NUM_IN_FLIGHT with no loss of order.

Reset
REQ-027 While MReset_n=0, the module SHALL hold:
- state ARB_FREE and last_grant=1;
- FIFO empty;
- out.MCmd=IDLE, both in_x.SCmdAccept=0 and out.MRespAccept=0.
REQ-028 Reset asserted mid-transaction SHALL discard all pending response routing; after release the first command SHALL be arbitrated as from ARB_FREE.

Structure
REQ-029 The arbiter state enum type SHALL be declared in package Bus, which also supplies the Bus::IDLE and Bus::NULL literals.
REQ-030 The response-select FIFO SHALL be a separate sub-module, bus_sel_fifo:
- parameters WIDTH and DEPTH;
- ports Clk, MReset_n, push, pop, data_in, data_out, full, empty;
- asynchronous clear; memory contents not reset.

Verification
REQ-031 Both ports issue RD in the same cycle after reset, slave always accepts -> in_0 accepted in cycle 0, in_1 in cycle 1, last_grant=1.
REQ-032 in_1 issues WR while out.SCmdAccept=0 for 3 cycles, and in_0 raises RD in cycle 1 -> grant stays on in_1 (ARB_HOLD_1); in_1 accepted in cycle 3, in_0 accepted in cycle 4.
REQ-033 5 commands from in_0 with NUM_IN_FLIGHT=4 and no responses -> 4 accepted; the 5th sees SCmdAccept=0 and out.MCmd=IDLE until one DVA response is popped.
REQ-034 Accepted order in_0, in_1, in_0; slave returns DVA with SData 0xA, 0xB, 0xC -> in_0 receives 0xA, in_1 receives 0xB, in_0 receives 0xC; the non-head port sees NULL throughout.
REQ-035 in_1.MRespAccept=0 for 2 cycles while out.SResp=DVA -> out.MRespAccept=0 and no pop; the pop occurs in the cycle MRespAccept rises.
REQ-036 MReset_n dropped with 2 responses pending -> after release empty=1, in_x.SResp=NULL, and a new RD is forwarded in the first cycle.

Source files
------------

// File: rtl/bus_if_merge_pkg.sv
// Bus package: command/response encodings, arbiter states and the command payload.
package Bus;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2
  } cmd_e;

  typedef enum logic [1:0] {
    NULL = 2'd0,
    DVA  = 2'd1,
    ERR  = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    ARB_FREE   = 2'd0,
    ARB_HOLD_0 = 2'd1,
    ARB_HOLD_1 = 2'd2
  } arb_state_e;

  // Master-side command fields carried through the merge mux
  typedef struct packed {
    cmd_e              cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } cmd_payload_t;

endpackage

// File: rtl/bus_if.sv
// Point-to-point command/response bus between one master and one slave.
interface Bus_if;
  import Bus::*;

  logic              MReset_n;
  cmd_e              MCmd;
  logic [ADDR_W-1:0] MAddr;
  logic [DATA_W-1:0] MData;
  logic [BE_W-1:0]   MByteEn;
  logic              MRespAccept;
  logic              SCmdAccept;
  resp_e             SResp;
  logic [DATA_W-1:0] SData;

  modport master (
    output MReset_n, MCmd, MAddr, MData, MByteEn, MRespAccept,
    input  SCmdAccept, SResp, SData
  );

  modport slave (
    input  MReset_n, MCmd, MAddr, MData, MByteEn, MRespAccept,
    output SCmdAccept, SResp, SData
  );

endinterface

// File: rtl/bus_sel_fifo.sv
// Small FIFO recording which master owns each outstanding response.
module bus_sel_fifo
  import Bus::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic             Clk,
  input  logic             MReset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Pointers wrap at DEPTH, which need not be a power of two
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full     = (r_count == CNT_W'(DEPTH));
  assign empty    = (r_count == '0);
  assign w_push   = push && !full;
  assign w_pop    = pop && !empty;
  assign data_out = r_mem[r_rd_ptr];

  // Storage array; contents are don't-care until written
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge Clk or negedge MReset_n) begin
    if (!MReset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bus_if_merge.sv
// Two-master to one-slave merge with round-robin arbitration and in-order response routing.
module bus_if_merge
  import Bus::*;
#(
  parameter int unsigned NUM_IN_FLIGHT = 4
) (
  input  logic Clk,
  input  logic MReset_n,
  Bus_if.slave  in_0,
  Bus_if.slave  in_1,
  Bus_if.master out
);

  arb_state_e   r_state;
  arb_state_e   w_state_nxt;
  logic         r_last_grant;
  logic         w_last_grant_nxt;

  logic         w_req_0;
  logic         w_req_1;
  logic         w_gnt_vld;
  logic         w_gnt_idx;
  logic         w_cmd_acc;
  logic         w_push;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  logic         w_head;
  logic         w_head_racc;

  cmd_payload_t w_pl_0;
  cmd_payload_t w_pl_1;
  cmd_payload_t w_pl_gnt;

  assign out.MReset_n = MReset_n;

  assign w_req_0 = (in_0.MCmd != IDLE);
  assign w_req_1 = (in_1.MCmd != IDLE);

  assign w_pl_0 = '{cmd: in_0.MCmd, addr: in_0.MAddr, data: in_0.MData, be: in_0.MByteEn};
  assign w_pl_1 = '{cmd: in_1.MCmd, addr: in_1.MAddr, data: in_1.MData, be: in_1.MByteEn};

  // Grant decode: held port wins outright, otherwise round-robin on a tie
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = 1'b0;
    case (r_state)
      ARB_HOLD_0: begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = 1'b0;
      end
      ARB_HOLD_1: begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = 1'b1;
      end
      default: begin
        if (w_req_0 && w_req_1) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = ~r_last_grant;
        end else if (w_req_0) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = 1'b0;
        end else if (w_req_1) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = 1'b1;
        end
      end
    endcase
  end

  // Command path: pure mux, blocked while the routing FIFO is full or in reset
  assign w_pl_gnt = (w_gnt_vld && w_gnt_idx) ? w_pl_1 : w_pl_0;

  assign out.MAddr   = w_pl_gnt.addr;
  assign out.MData   = w_pl_gnt.data;
  assign out.MByteEn = w_pl_gnt.be;
  assign out.MCmd    = (MReset_n && w_gnt_vld && !w_full) ? w_pl_gnt.cmd : IDLE;

  assign w_cmd_acc       = MReset_n && w_gnt_vld && !w_full && out.SCmdAccept;
  assign in_0.SCmdAccept = w_cmd_acc && !w_gnt_idx;
  assign in_1.SCmdAccept = w_cmd_acc && w_gnt_idx;

  assign w_push = (out.MCmd != IDLE) && out.SCmdAccept;

  // Arbiter next state: park on a refused grant until it is taken
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      ARB_HOLD_0, ARB_HOLD_1: begin
        if (w_push) begin
          w_state_nxt = ARB_FREE;
        end
      end
      default: begin
        if (w_gnt_vld && !w_push) begin
          w_state_nxt = w_gnt_idx ? ARB_HOLD_1 : ARB_HOLD_0;
        end
      end
    endcase
    if (w_push) begin
      w_last_grant_nxt = w_gnt_idx;
    end
  end

  // Arbiter state and last-grant registers
  always_ff @(posedge Clk or negedge MReset_n) begin
    if (!MReset_n) begin
      r_state      <= ARB_FREE;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  bus_sel_fifo #(
    .WIDTH (1),
    .DEPTH (NUM_IN_FLIGHT)
  ) u_sel_fifo (
    .Clk      (Clk),
    .MReset_n (MReset_n),
    .push     (w_push),
    .pop      (w_pop),
    .data_in  (w_gnt_idx),
    .data_out (w_head),
    .full     (w_full),
    .empty    (w_empty)
  );

  // Response path: steer slave response to the owner at the FIFO head
  assign w_head_racc      = w_head ? in_1.MRespAccept : in_0.MRespAccept;
  assign out.MRespAccept  = !w_empty && w_head_racc;
  assign w_pop            = !w_empty && (out.SResp != NULL) && w_head_racc;

  assign in_0.SResp = (!w_empty && !w_head) ? out.SResp : NULL;
  assign in_0.SData = (!w_empty && !w_head) ? out.SData : '0;
  assign in_1.SResp = (!w_empty && w_head)  ? out.SResp : NULL;
  assign in_1.SData = (!w_empty && w_head)  ? out.SData : '0;

endmodule

// File: tb/tb_bus_if_merge.sv
// Directed bench for bus_if_merge: arbitration, hold, full blocking, response routing, reset.
module tb_bus_if_merge;
  import Bus::*;

  logic clk = 1'b0;
  logic rst_n;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  Bus_if u_in_0 ();
  Bus_if u_in_1 ();
  Bus_if u_out ();

  assign u_in_0.MReset_n = rst_n;
  assign u_in_1.MReset_n = rst_n;

  bus_if_merge #(
    .NUM_IN_FLIGHT (4)
  ) dut (
    .Clk      (clk),
    .MReset_n (rst_n),
    .in_0     (u_in_0),
    .in_1     (u_in_1),
    .out      (u_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int p, input cmd_e c, input logic [31:0] a);
    if (p == 0) begin
      u_in_0.MCmd    = c;
      u_in_0.MAddr   = a;
      u_in_0.MData   = a ^ 32'hFFFF_0000;
      u_in_0.MByteEn = 4'hF;
    end else begin
      u_in_1.MCmd    = c;
      u_in_1.MAddr   = a;
      u_in_1.MData   = a ^ 32'h0000_FFFF;
      u_in_1.MByteEn = 4'h3;
    end
  endtask

  task automatic set_racc(input logic a0, input logic a1);
    u_in_0.MRespAccept = a0;
    u_in_1.MRespAccept = a1;
  endtask

  task automatic set_s(input logic acc, input resp_e r, input logic [31:0] d);
    u_out.SCmdAccept = acc;
    u_out.SResp      = r;
    u_out.SData      = d;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      set_s(1'b1, DVA, 32'hD0 + 32'(i));
      set_racc(1'b1, 1'b1);
    end
    @(negedge clk);
    set_s(1'b1, NULL, 32'h0);
    set_racc(1'b0, 1'b0);
    #1 check_val("drain_empty", 32'(dut.w_empty), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    set_m(0, RD, 32'h10);
    set_m(1, IDLE, 32'h0);
    set_racc(1'b0, 1'b0);
    set_s(1'b1, NULL, 32'h0);

    // Reset values, with a live request on in_0 that must be suppressed
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_out_mcmd",   32'(u_out.MCmd),        32'(IDLE));
    check_val("rst_in0_acc",    32'(u_in_0.SCmdAccept), 32'd0);
    check_val("rst_in1_acc",    32'(u_in_1.SCmdAccept), 32'd0);
    check_val("rst_racc",       32'(u_out.MRespAccept), 32'd0);
    check_val("rst_out_reset",  32'(u_out.MReset_n),    32'd0);
    check_val("rst_empty",      32'(dut.w_empty),       32'd1);
    check_val("rst_last_grant", 32'(dut.r_last_grant),  32'd1);
    check_val("rst_state",      32'(dut.r_state),       32'(ARB_FREE));

    @(negedge clk);
    rst_n = 1'b1;
    set_m(0, IDLE, 32'h0);

    // Simultaneous RD on both ports: in_0 first, then in_1
    @(negedge clk);
    set_m(0, RD, 32'h100);
    set_m(1, RD, 32'h200);
    #1;
    check_val("t1_c0_mcmd",  32'(u_out.MCmd),        32'(RD));
    check_val("t1_c0_addr",  u_out.MAddr,            32'h100);
    check_val("t1_c0_acc0",  32'(u_in_0.SCmdAccept), 32'd1);
    check_val("t1_c0_acc1",  32'(u_in_1.SCmdAccept), 32'd0);
    @(negedge clk);
    set_m(0, IDLE, 32'h0);
    #1;
    check_val("t1_c1_addr",  u_out.MAddr,            32'h200);
    check_val("t1_c1_data",  u_out.MData,            32'h0000_FDFF);
    check_val("t1_c1_acc1",  32'(u_in_1.SCmdAccept), 32'd1);
    check_val("t1_c1_acc0",  32'(u_in_0.SCmdAccept), 32'd0);
    @(negedge clk);
    set_m(1, IDLE, 32'h0);
    #1;
    check_val("t1_last_grant", 32'(dut.r_last_grant), 32'd1);
    check_val("t1_mcmd_idle",  32'(u_out.MCmd),       32'(IDLE));
    drain(2);

    // in_1 WR refused for 3 cycles; in_0 RD arrives in cycle 1 and must wait
    @(negedge clk);
    set_m(1, WR, 32'h300);
    set_s(1'b0, NULL, 32'h0);
    #1;
    check_val("t2_c0_mcmd", 32'(u_out.MCmd),        32'(WR));
    check_val("t2_c0_acc1", 32'(u_in_1.SCmdAccept), 32'd0);
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      set_m(0, RD, 32'h400);
      #1;
      check_val("t2_hold_addr",  u_out.MAddr,            32'h300);
      check_val("t2_hold_acc0",  32'(u_in_0.SCmdAccept), 32'd0);
      check_val("t2_hold_state", 32'(dut.r_state),       32'(ARB_HOLD_1));
    end
    @(negedge clk);
    set_s(1'b1, NULL, 32'h0);
    #1;
    check_val("t2_c3_addr", u_out.MAddr,            32'h300);
    check_val("t2_c3_acc1", 32'(u_in_1.SCmdAccept), 32'd1);
    check_val("t2_c3_acc0", 32'(u_in_0.SCmdAccept), 32'd0);
    @(negedge clk);
    set_m(1, IDLE, 32'h0);
    #1;
    check_val("t2_c4_state", 32'(dut.r_state),       32'(ARB_FREE));
    check_val("t2_c4_addr",  u_out.MAddr,            32'h400);
    check_val("t2_c4_acc0",  32'(u_in_0.SCmdAccept), 32'd1);
    @(negedge clk);
    set_m(0, IDLE, 32'h0);
    drain(2);

    // Five commands from in_0, no responses: fifth blocked until a pop lands
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_m(0, RD, 32'h500 + 32'(k));
      #1 check_val("t3_acc_k", 32'(u_in_0.SCmdAccept), 32'd1);
    end
    @(negedge clk);
    set_m(0, RD, 32'h504);
    #1;
    check_val("t3_full_acc",  32'(u_in_0.SCmdAccept), 32'd0);
    check_val("t3_full_mcmd", 32'(u_out.MCmd),        32'(IDLE));
    check_val("t3_full_flag", 32'(dut.w_full),        32'd1);
    @(negedge clk);
    set_s(1'b1, DVA, 32'h77);
    set_racc(1'b1, 1'b0);
    #1;
    check_val("t3_pop_mcmd", 32'(u_out.MCmd),        32'(IDLE));
    check_val("t3_pop_acc",  32'(u_in_0.SCmdAccept), 32'd0);
    check_val("t3_pop_racc", 32'(u_out.MRespAccept), 32'd1);
    check_val("t3_pop_data", u_in_0.SData,           32'h77);
    @(negedge clk);
    set_s(1'b1, NULL, 32'h0);
    set_racc(1'b0, 1'b0);
    #1;
    check_val("t3_unblk_mcmd", 32'(u_out.MCmd),        32'(RD));
    check_val("t3_unblk_addr", u_out.MAddr,            32'h504);
    check_val("t3_unblk_acc",  32'(u_in_0.SCmdAccept), 32'd1);
    @(negedge clk);
    set_m(0, IDLE, 32'h0);
    drain(4);

    // Order in_0, in_1, in_0 with responses 0xA, 0xB, 0xC
    @(negedge clk);
    set_m(0, RD, 32'h600);
    #1 check_val("t4_a_acc0", 32'(u_in_0.SCmdAccept), 32'd1);
    @(negedge clk);
    set_m(0, IDLE, 32'h0);
    set_m(1, RD, 32'h610);
    #1 check_val("t4_b_acc1", 32'(u_in_1.SCmdAccept), 32'd1);
    @(negedge clk);
    set_m(1, IDLE, 32'h0);
    set_m(0, RD, 32'h620);
    #1 check_val("t4_c_acc0", 32'(u_in_0.SCmdAccept), 32'd1);
    @(negedge clk);
    set_m(0, IDLE, 32'h0);
    set_s(1'b1, DVA, 32'hA);
    set_racc(1'b1, 1'b1);
    #1;
    check_val("t4_ra_resp0", 32'(u_in_0.SResp), 32'(DVA));
    check_val("t4_ra_data0", u_in_0.SData,      32'hA);
    check_val("t4_ra_resp1", 32'(u_in_1.SResp), 32'(NULL));
    check_val("t4_ra_data1", u_in_1.SData,      32'h0);
    @(negedge clk);
    set_s(1'b1, DVA, 32'hB);
    #1;
    check_val("t4_rb_resp1", 32'(u_in_1.SResp), 32'(DVA));
    check_val("t4_rb_data1", u_in_1.SData,      32'hB);
    check_val("t4_rb_resp0", 32'(u_in_0.SResp), 32'(NULL));
    check_val("t4_rb_data0", u_in_0.SData,      32'h0);
    @(negedge clk);
    set_s(1'b1, DVA, 32'hC);
    #1;
    check_val("t4_rc_resp0", 32'(u_in_0.SResp), 32'(DVA));
    check_val("t4_rc_data0", u_in_0.SData,      32'hC);
    check_val("t4_rc_resp1", 32'(u_in_1.SResp), 32'(NULL));
    @(negedge clk);
    set_s(1'b1, NULL, 32'h0);
    set_racc(1'b0, 1'b0);
    #1 check_val("t4_empty", 32'(dut.w_empty), 32'd1);

    // in_1 stalls its response for 2 cycles; pop only when it accepts
    @(negedge clk);
    set_m(1, WR, 32'h700);
    #1 check_val("t5_acc1", 32'(u_in_1.SCmdAccept), 32'd1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      set_m(1, IDLE, 32'h0);
      set_s(1'b1, DVA, 32'h55);
      set_racc(1'b1, 1'b0);
      #1;
      check_val("t5_stall_racc",  32'(u_out.MRespAccept), 32'd0);
      check_val("t5_stall_resp1", 32'(u_in_1.SResp),      32'(DVA));
      check_val("t5_stall_empty", 32'(dut.w_empty),       32'd0);
    end
    @(negedge clk);
    set_racc(1'b0, 1'b1);
    #1;
    check_val("t5_rise_racc",  32'(u_out.MRespAccept), 32'd1);
    check_val("t5_rise_empty", 32'(dut.w_empty),       32'd0);
    @(negedge clk);
    set_s(1'b1, NULL, 32'h0);
    set_racc(1'b0, 1'b0);
    #1 check_val("t5_popped", 32'(dut.w_empty), 32'd1);

    // Reset with two responses pending
    @(negedge clk);
    set_m(0, RD, 32'h800);
    #1 check_val("t6_acc0", 32'(u_in_0.SCmdAccept), 32'd1);
    @(negedge clk);
    set_m(0, IDLE, 32'h0);
    set_m(1, RD, 32'h810);
    #1 check_val("t6_acc1", 32'(u_in_1.SCmdAccept), 32'd1);
    @(negedge clk);
    set_m(1, IDLE, 32'h0);
    #1 check_val("t6_pending", 32'(dut.w_empty), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    set_s(1'b1, DVA, 32'h99);
    set_racc(1'b1, 1'b1);
    #1;
    check_val("t6_rst_empty", 32'(dut.w_empty),    32'd1);
    check_val("t6_rst_oreset", 32'(u_out.MReset_n), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("t6_rel_empty", 32'(dut.w_empty),       32'd1);
    check_val("t6_rel_resp0", 32'(u_in_0.SResp),      32'(NULL));
    check_val("t6_rel_resp1", 32'(u_in_1.SResp),      32'(NULL));
    check_val("t6_rel_racc",  32'(u_out.MRespAccept), 32'd0);
    @(negedge clk);
    set_s(1'b1, NULL, 32'h0);
    set_racc(1'b0, 1'b0);
    set_m(0, RD, 32'h900);
    set_m(1, RD, 32'h910);
    #1;
    check_val("t6_new_mcmd", 32'(u_out.MCmd),        32'(RD));
    check_val("t6_new_addr", u_out.MAddr,            32'h900);
    check_val("t6_new_acc0", 32'(u_in_0.SCmdAccept), 32'd1);
    @(negedge clk);
    set_m(0, IDLE, 32'h0);
    set_m(1, IDLE, 32'h0);
    @(negedge clk);
    drain(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
